// File: rtl/arp_cache.sv
// IPv4-to-MAC association table with learn/age/flush maintenance and a
// sequential one-entry-per-cycle lookup scan.
module arp_cache #(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned AGE_W   = 8,
  parameter int unsigned MAX_AGE = 255,
  localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             learn_valid,
  input  logic [31:0]      learn_spa,
  input  logic [47:0]      learn_sha,
  input  logic             lookup_valid,
  input  logic [31:0]      lookup_ip,
  output logic             lookup_ready,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [47:0]      resp_mac,
  input  logic             age_tick,
  input  logic             flush,
  output logic [IDX_W:0]   occupancy
);

  localparam logic [AGE_W-1:0] AgeLast = AGE_W'(MAX_AGE - 1);
  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(ENTRIES - 1);

  typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [31:0]        ip_q  [ENTRIES];
  logic [31:0]        ip_d  [ENTRIES];
  logic [47:0]        mac_q [ENTRIES];
  logic [47:0]        mac_d [ENTRIES];
  logic [AGE_W-1:0]   age_q [ENTRIES];
  logic [AGE_W-1:0]   age_d [ENTRIES];
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W:0]     occ_q, occ_d;

  logic [ENTRIES-1:0] match;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        lk_ip_q;
  logic               hit_q;
  logic [47:0]        rmac_q;
  logic               cur_match;

  // Table maintenance; later assignments override earlier ones so that
  // flush beats learn, and learn beats aging on the same entry.
  always_comb begin
    valid_d    = valid_q;
    ip_d       = ip_q;
    mac_d      = mac_q;
    age_d      = age_q;
    ptr_d      = ptr_q;
    match      = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match[i] = valid_q[i] && (ip_q[i] == learn_spa);
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    if (age_tick) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (valid_q[i]) begin
          if (age_q[i] == AgeLast) begin
            valid_d[i] = 1'b0;
            age_d[i]   = '0;
          end else begin
            age_d[i] = age_q[i] + 1'b1;
          end
        end
      end
    end
    if (learn_valid && (learn_spa != 32'd0)) begin
      if (|match) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (match[i]) begin
            valid_d[i] = 1'b1;
            mac_d[i]   = learn_sha;
            age_d[i]   = '0;
          end
        end
      end else if (free_found) begin
        valid_d[free_idx] = 1'b1;
        ip_d[free_idx]    = learn_spa;
        mac_d[free_idx]   = learn_sha;
        age_d[free_idx]   = '0;
      end else begin
        valid_d[ptr_q] = 1'b1;
        ip_d[ptr_q]    = learn_spa;
        mac_d[ptr_q]   = learn_sha;
        age_d[ptr_q]   = '0;
        ptr_d          = ptr_q + 1'b1;
      end
    end
    if (flush) begin
      valid_d = '0;
    end
    occ_d = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      occ_d = occ_d + {{IDX_W{1'b0}}, valid_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      ptr_q   <= '0;
      occ_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ip_q[i]  <= '0;
        mac_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ip_q    <= ip_d;
      mac_q   <= mac_d;
      age_q   <= age_d;
      ptr_q   <= ptr_d;
      occ_q   <= occ_d;
    end
  end

  assign cur_match = valid_q[idx_q] && (ip_q[idx_q] == lk_ip_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (lookup_valid) state_d = StScan;
      StScan:  if (cur_match || (idx_q == IdxLast)) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    lookup_ready = (state_q == StIdle);
    resp_valid   = (state_q == StResp);
    resp_hit     = hit_q;
    resp_mac     = rmac_q;
    occupancy    = occ_q;
  end

  // Scan datapath; response fields hold until the next scan completes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q   <= '0;
      lk_ip_q <= '0;
      hit_q   <= 1'b0;
      rmac_q  <= '0;
    end else if ((state_q == StIdle) && lookup_valid) begin
      idx_q   <= '0;
      lk_ip_q <= lookup_ip;
    end else if (state_q == StScan) begin
      if (cur_match) begin
        hit_q  <= 1'b1;
        rmac_q <= mac_q[idx_q];
      end else if (idx_q == IdxLast) begin
        hit_q  <= 1'b0;
        rmac_q <= '0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arp_cache.sv
// Directed bench for arp_cache: a vector table of learn/lookup/tick/flush
// operations plus hand-written sequences for concurrent and reset cases.
module tb_arp_cache;

  localparam int unsigned ENTRIES = 4;
  localparam int unsigned AGE_W   = 8;
  localparam int unsigned MAX_AGE = 3;
  localparam int unsigned IDX_W   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             learn_valid = 1'b0;
  logic [31:0]      learn_spa = '0;
  logic [47:0]      learn_sha = '0;
  logic             lookup_valid = 1'b0;
  logic [31:0]      lookup_ip = '0;
  logic             lookup_ready;
  logic             resp_valid;
  logic             resp_hit;
  logic [47:0]      resp_mac;
  logic             age_tick = 1'b0;
  logic             flush = 1'b0;
  logic [IDX_W:0]   occupancy;

  int checks = 0;
  int errors = 0;

  arp_cache #(
    .ENTRIES (ENTRIES),
    .AGE_W   (AGE_W),
    .MAX_AGE (MAX_AGE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .learn_valid  (learn_valid),
    .learn_spa    (learn_spa),
    .learn_sha    (learn_sha),
    .lookup_valid (lookup_valid),
    .lookup_ip    (lookup_ip),
    .lookup_ready (lookup_ready),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_mac     (resp_mac),
    .age_tick     (age_tick),
    .flush        (flush),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  typedef enum int {OpLearn, OpLookup, OpTick, OpFlush} op_e;
  typedef struct {
    op_e         op;
    logic [31:0] ip;
    logic [47:0] mac;
    logic        hit;
    logic [47:0] emac;
    int          lat;
    int          occ;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] ipa(input logic [7:0] n);
    return {24'h0a0000, n};
  endfunction

  function automatic logic [47:0] macf(input logic [7:0] n);
    return {40'h0200000000, n};
  endfunction

  function automatic vec_t v(input op_e op, input logic [31:0] ip, input logic [47:0] mac,
                             input logic hit, input logic [47:0] emac, input int lat,
                             input int occ);
    vec_t r;
    r.op = op; r.ip = ip; r.mac = mac; r.hit = hit; r.emac = emac; r.lat = lat; r.occ = occ;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic learn(input logic [31:0] ip, input logic [47:0] mac);
    learn_valid = 1'b1; learn_spa = ip; learn_sha = mac;
    @(posedge clk); #1;
    learn_valid = 1'b0;
  endtask

  task automatic tick();
    age_tick = 1'b1;
    @(posedge clk); #1;
    age_tick = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // lat counts edges after the accepting edge until resp_valid is seen.
  task automatic lookup(input logic [31:0] ip, input int flush_at, output logic hit,
                        output logic [47:0] mac, output int lat);
    chk("ready_before_lookup", 64'(lookup_ready), 64'd1);
    lookup_valid = 1'b1; lookup_ip = ip;
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    lat = -1; hit = 1'bx; mac = 'x;
    for (int k = 0; k < 20; k++) begin
      if (resp_valid) begin
        lat = k; hit = resp_hit; mac = resp_mac;
        break;
      end
      flush = (k == flush_at);
      @(posedge clk); #1;
      flush = 1'b0;
    end
    @(posedge clk); #1;
    chk("resp_single_cycle", 64'(resp_valid), 64'd0);
  endtask

  task automatic lookup_chk(input string name, input logic [31:0] ip, input int flush_at,
                            input logic ehit, input logic [47:0] emac, input int elat);
    logic        h;
    logic [47:0] m;
    int          l;
    lookup(ip, flush_at, h, m, l);
    chk({name, "_lat"}, 64'(l), 64'(elat));
    chk({name, "_hit"}, 64'(h), 64'(ehit));
    chk({name, "_mac"}, 64'(m), 64'(emac));
  endtask

  initial begin
    logic seen;
    // Basic learn/lookup, probe filtering, replacement and aging.
    vecs.push_back(v(OpLearn,  ipa(1), macf(1), 0, 0, 0, 1));
    vecs.push_back(v(OpLearn,  ipa(2), macf(2), 0, 0, 0, 2));
    vecs.push_back(v(OpLookup, ipa(2), 0, 1, macf(2), 2, 2));
    vecs.push_back(v(OpLookup, ipa(9), 0, 0, 0, 4, 2));
    vecs.push_back(v(OpLearn,  32'd0, 48'hff, 0, 0, 0, 2));
    vecs.push_back(v(OpLookup, 32'd0, 0, 0, 0, 4, 2));
    vecs.push_back(v(OpLearn,  ipa(3), macf(3), 0, 0, 0, 3));
    vecs.push_back(v(OpLearn,  ipa(4), macf(4), 0, 0, 0, 4));
    vecs.push_back(v(OpLearn,  ipa(5), macf(5), 0, 0, 0, 4));
    vecs.push_back(v(OpLookup, ipa(1), 0, 0, 0, 4, 4));
    vecs.push_back(v(OpLookup, ipa(5), 0, 1, macf(5), 1, 4));
    vecs.push_back(v(OpLearn,  ipa(2), macf(8'h22), 0, 0, 0, 4));
    vecs.push_back(v(OpLookup, ipa(2), 0, 1, macf(8'h22), 2, 4));
    vecs.push_back(v(OpLearn,  ipa(6), macf(6), 0, 0, 0, 4));
    vecs.push_back(v(OpLookup, ipa(6), 0, 1, macf(6), 2, 4));
    vecs.push_back(v(OpLookup, ipa(2), 0, 0, 0, 4, 4));
    vecs.push_back(v(OpLookup, ipa(3), 0, 1, macf(3), 3, 4));
    vecs.push_back(v(OpFlush,  0, 0, 0, 0, 0, 0));
    vecs.push_back(v(OpLearn,  ipa(1), macf(1), 0, 0, 0, 1));
    vecs.push_back(v(OpTick,   0, 0, 0, 0, 0, 1));
    vecs.push_back(v(OpTick,   0, 0, 0, 0, 0, 1));
    vecs.push_back(v(OpLookup, ipa(1), 0, 1, macf(1), 1, 1));
    vecs.push_back(v(OpLearn,  ipa(1), macf(8'h11), 0, 0, 0, 1));
    vecs.push_back(v(OpTick,   0, 0, 0, 0, 0, 1));
    vecs.push_back(v(OpLookup, ipa(1), 0, 1, macf(8'h11), 1, 1));
    vecs.push_back(v(OpTick,   0, 0, 0, 0, 0, 1));
    vecs.push_back(v(OpTick,   0, 0, 0, 0, 0, 0));
    vecs.push_back(v(OpLookup, ipa(1), 0, 0, 0, 4, 0));

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst_ready", 64'(lookup_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_hit", 64'(resp_hit), 64'd0);
    chk("rst_resp_mac", 64'(resp_mac), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OpLearn:  learn(vecs[i].ip, vecs[i].mac);
        OpLookup: lookup_chk($sformatf("vec%0d", i), vecs[i].ip, -1, vecs[i].hit,
                             vecs[i].emac, vecs[i].lat);
        OpTick:   tick();
        default:  do_flush();
      endcase
      chk($sformatf("vec%0d_occ", i), 64'(occupancy), 64'(vecs[i].occ));
    end

    // Learn and flush together: flush wins.
    learn(ipa(8), macf(8));
    chk("pre_flush_occ", 64'(occupancy), 64'd1);
    flush = 1'b1;
    learn(ipa(7), macf(7));
    flush = 1'b0;
    chk("learn_flush_occ", 64'(occupancy), 64'd0);
    lookup_chk("learn_flush_lk", ipa(7), -1, 0, 0, 4);

    // Replacement pointer (2 after two evictions) survives flushes.
    learn(ipa(1), macf(1)); learn(ipa(2), macf(2));
    learn(ipa(3), macf(3)); learn(ipa(4), macf(4));
    learn(ipa(9), macf(9));
    chk("ptr_occ", 64'(occupancy), 64'd4);
    lookup_chk("ptr_new", ipa(9), -1, 1, macf(9), 3);
    lookup_chk("ptr_old", ipa(3), -1, 0, 0, 4);
    do_flush();

    // Only .1 at entry 3, then flush mid-scan before the scan reaches it.
    learn(ipa(10), macf(10)); learn(ipa(11), macf(11)); learn(ipa(12), macf(12));
    tick(); tick();
    learn(ipa(1), macf(1));
    tick();
    chk("lone_occ", 64'(occupancy), 64'd1);
    lookup_chk("lone_hit", ipa(1), -1, 1, macf(1), 4);
    lookup_chk("scan_flush", ipa(1), 1, 0, 0, 4);
    chk("scan_flush_occ", 64'(occupancy), 64'd0);

    // Reset in the middle of a scan.
    learn(ipa(20), macf(20)); learn(ipa(21), macf(21));
    lookup_chk("pre_rst", ipa(20), -1, 1, macf(20), 1);
    lookup_valid = 1'b1; lookup_ip = ipa(99);
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("mid_rst_ready", 64'(lookup_ready), 64'd1);
    chk("mid_rst_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_hit", 64'(resp_hit), 64'd0);
    chk("mid_rst_mac", 64'(resp_mac), 64'd0);
    chk("mid_rst_occ", 64'(occupancy), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      seen |= resp_valid;
      @(posedge clk); #1;
    end
    chk("mid_rst_no_resp", 64'(seen), 64'd0);
    learn(ipa(30), macf(30));
    chk("post_rst_occ", 64'(occupancy), 64'd1);
    lookup_chk("post_rst_lk", ipa(30), -1, 1, macf(30), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arp_cache.md
Name: arp_cache

Overview:
- N-entry IPv4-to-MAC association table fed by the ARP decoder's sender fields (spa/sha) once a frame has decoded cleanly.
- Answers lookup requests from the IP transmit path with a MAC address, or a miss so that path can trigger an ARP request through the encoder.
- Parametrised in depth and aging.
- Lookups use a sequential one-entry-per-cycle scan so the table can grow without a wide parallel comparator.

Parameters:
- ENTRIES, 4: number of table entries; integer >= 2, power of two. IDX_W = $clog2(ENTRIES), derived.
- AGE_W, 8: width of the per-entry age counter.
- MAX_AGE, 255: age value at which an entry expires; 1..2^AGE_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- learn_valid  in  1  one-cycle pulse; learn_spa/learn_sha valid (decoder done && !err)
- learn_spa  in  32  sender IPv4 address
- learn_sha  in  48  sender MAC address
- lookup_valid  in  1  lookup request
- lookup_ip  in  32  IPv4 address to resolve
- lookup_ready  out  1  block can accept a lookup
- resp_valid  out  1  one-cycle response strobe
- resp_hit  out  1  qualified by resp_valid; 1 = found
- resp_mac  out  48  qualified by resp_valid; MAC on hit, 0 on miss
- age_tick  in  1  one-cycle aging pulse from a system timer
- flush  in  1  invalidate entire table
- occupancy  out  IDX_W+1  count of valid entries

Behaviour:
- Reset (rst=0 at posedge):
  - All entries invalid, ages 0, replacement pointer 0, FSM IDLE.
  - resp_valid=0, resp_hit=0, resp_mac=0, occupancy=0.
  - lookup_ready=1, since it is derived from state == IDLE.
  - Reset mid-scan aborts with no response.
- Entry contents: valid bit, ip[31:0], mac[47:0], age[AGE_W-1:0].
- Learn, applied at the posedge where learn_valid=1:
  - learn_spa == 0 (ARP probe): ignored.
  - IP matches a valid entry (parallel compare): overwrite mac, age=0. Never more than one entry per IP.
  - Else, an invalid entry exists: write into the lowest-index invalid entry, valid=1, age=0.
  - Else (table full): overwrite the entry at the replacement pointer, then pointer = pointer+1 mod ENTRIES. The pointer advances only on eviction.
- Aging, on age_tick=1:
  - Every valid entry with age < MAX_AGE-1: age+1.
  - Entry with age == MAX_AGE-1: invalidated.
  - Invalid entries untouched.
- Priorities:
  - flush > learn > age_tick.
  - Learn and tick on the same entry in one cycle: learn wins (age=0, entry stays valid). Other entries still age.
  - Learn and flush in the same cycle: all invalid, learn dropped.
  - Flush does not reset the replacement pointer.
- Lookup FSM, states IDLE, SCAN, RESP:
  - IDLE: lookup_ready=1. lookup_valid=1 at cycle T: capture lookup_ip, idx=0, go to SCAN.
  - SCAN: each cycle compare entry idx against the captured IP using live table contents.
    - Valid match: latch mac, hit=1, go to RESP.
    - Else if idx == ENTRIES-1: hit=0, mac=0, go to RESP.
    - Else idx+1.
  - RESP: resp_valid=1 for exactly one cycle with resp_hit/resp_mac. Return to IDLE; the next lookup is accepted no earlier than the following cycle.
  - Latency: hit at entry i gives resp_valid at cycle T+2+i. Miss gives resp_valid at cycle T+1+ENTRIES.
  - lookup_ready=0 in SCAN and RESP. lookup_valid outside IDLE is ignored.
- Concurrency with scans:
  - Learn, age or flush during a scan take effect at their edge.
  - Entries already passed are not rescanned.
  - A flush mid-scan yields a miss unless the hit was already latched.
- resp_mac and resp_hit hold their values between responses.
- occupancy is registered and updated on the same edge as the table change.

Test Plan:
- Learn 10.0.0.1 / 02:00:00:00:00:01 and 10.0.0.2 / 02:..:02, then look up 10.0.0.2: resp_valid at T+3, hit=1, mac=02:00:00:00:00:02, occupancy=2.
- Look up 10.0.0.9 on the same table (ENTRIES=4): resp_valid at T+5, hit=0, mac=0. Assert learn_valid with spa=0: occupancy unchanged.
- Learn IPs .1 through .5 in sequence: .5 replaces entry 0 (pointer becomes 1). Lookup of .1 misses, lookup of .5 hits with its MAC, occupancy=4.
- MAX_AGE=3: learn .1, pulse age_tick twice (entry valid, age 2), then re-learn .1 and tick once more: still hit. Two further ticks: miss, occupancy=0.
- Assert learn of .7 and flush in the same cycle: occupancy=0, lookup of .7 misses. Assert flush during a scan of a table holding only .1 at entry 3, before the scan reaches entry 3: miss.
- Pulse rst=0 mid-scan: no resp_valid, lookup_ready=1 the next cycle, all outputs at reset values, and a subsequent learn is stored in entry 0.
